// File: rtl/hazard_pkg.sv
// Shared constants and types for the RV32I hazard unit: forward-select encodings,
// register index width and the multi-cycle watchdog state encoding.
package hazard_pkg;

    localparam int REG_W = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        MC_IDLE = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forward-select for one E-stage operand. The M-stage result is newer than the
// W-stage result, so it wins when both match; x0 never forwards.
module hazard_fwd_sel
    import hazard_pkg::*;
(
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rd_m,
    input  logic [REG_W-1:0] rd_w,
    output logic [1:0]       sel
);

    always_comb begin
        sel = FWD_RF;
        if (rs != '0 && rs == rd_m) begin
            sel = FWD_MEM;
        end else if (rs != '0 && rs == rd_w) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard control for the 5-stage RV32I pipeline: forwarding, load-use stall,
// branch flush and a watchdog-guarded multi-cycle E-stage handshake.
// Optional perf counters (StallCycles/FlushCount/McCycles) under HAZARD_PERF_CNT_EN.
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int LOAD_USE_DIST = 1,
    parameter int MC_MAX        = 32,
    parameter int CNT_W         = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [REG_W-1:0]             Rs1D,
    input  logic [REG_W-1:0]             Rs2D,
    input  logic [REG_W-1:0]             Rs1E,
    input  logic [REG_W-1:0]             Rs2E,
    input  logic [REG_W-1:0]             RdE,
    input  logic [REG_W-1:0]             RdM,
    input  logic [REG_W-1:0]             RdW,
    input  logic                         LoadE,
    input  logic                         LoadM,
    input  logic                         PCSrcE,
    input  logic                         MulDivStartE,
    input  logic                         MulDivDoneE,
    output logic [1:0]                   ForwardAE,
    output logic [1:0]                   ForwardBE,
    output logic                         StallF,
    output logic                         StallD,
    output logic                         StallE,
    output logic                         FlushD,
    output logic                         FlushE,
    output logic                         FlushM,
    output logic                         McTimeout,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_W-1:0]             StallCycles,
    output logic [CNT_W-1:0]             FlushCount,
    output logic [CNT_W-1:0]             McCycles,
`endif
    output mc_state_t                    mc_state,
    output logic [$clog2(MC_MAX+1)-1:0]  mc_cnt
);

    localparam int                CW      = $clog2(MC_MAX + 1);
    localparam logic [CW-1:0]     CNT_MAX = CW'(MC_MAX);

    // Handshake: MulDivStartE is held high by the pipeline while the op sits in
    // E; MulDivDoneE is sampled only in BUSY, and the op leaves E on the edge
    // that ends the cycle in which the unit releases (done or watchdog).
    mc_state_t     state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          timeout_nxt;
    logic          mc_stall, lu_e, lu_m, lu_stall;
    logic [1:0]    fwd_a, fwd_b;

    hazard_fwd_sel u_fwd_a (.rs(Rs1E), .rd_m(RdM), .rd_w(RdW), .sel(fwd_a));
    hazard_fwd_sel u_fwd_b (.rs(Rs2E), .rd_m(RdM), .rd_w(RdW), .sel(fwd_b));

    assign lu_e     = LoadE && RdE != '0 && (RdE == Rs1D || RdE == Rs2D);
    assign lu_m     = LoadM && RdM != '0 && (RdM == Rs1D || RdM == Rs2D);
    assign lu_stall = lu_e || (LOAD_USE_DIST == 2 && lu_m);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= MC_IDLE;
            cnt       <= '0;
            McTimeout <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            McTimeout <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        timeout_nxt = 1'b0;
        case (state)
            MC_IDLE: begin
                if (MulDivStartE) begin
                    state_nxt = MC_BUSY;
                    cnt_nxt   = CW'(1);
                end
            end
            MC_BUSY: begin
                if (MulDivDoneE) begin
                    state_nxt = MC_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt   = MC_IDLE;
                    cnt_nxt     = '0;
                    timeout_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = MC_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        mc_stall = (state == MC_IDLE && MulDivStartE) ||
                   (state == MC_BUSY && !MulDivDoneE && cnt != CNT_MAX);
    end

    // A taken redirect squashes the dependent instruction, so it overrides the
    // load-use stall; a multi-cycle stall freezes everything including flushes.
    always_comb begin
        ForwardAE = fwd_a;
        ForwardBE = fwd_b;
        StallF    = mc_stall || (lu_stall && !PCSrcE);
        StallD    = mc_stall || (lu_stall && !PCSrcE);
        StallE    = mc_stall;
        FlushM    = mc_stall;
        FlushE    = (lu_stall || PCSrcE) && !mc_stall;
        FlushD    = PCSrcE && !mc_stall;
        if (reset) begin
            ForwardAE = FWD_RF;
            ForwardBE = FWD_RF;
            StallF    = 1'b0;
            StallD    = 1'b0;
            StallE    = 1'b0;
            FlushD    = 1'b1;
            FlushE    = 1'b1;
            FlushM    = 1'b1;
        end
    end

    assign mc_state = state;
    assign mc_cnt   = cnt;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            StallCycles <= '0;
            FlushCount  <= '0;
            McCycles    <= '0;
        end else begin
            if (StallF && StallCycles != '1) StallCycles <= StallCycles + 1'b1;
            if (FlushD && FlushCount != '1)  FlushCount  <= FlushCount + 1'b1;
            if (StallE && McCycles != '1)    McCycles    <= McCycles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc built with LOAD_USE_DIST=2, MC_MAX=8.
// Flag vectors are packed as {StallF, StallD, StallE, FlushD, FlushE, FlushM}.
module tb_hazard_unit_mc;
    import hazard_pkg::*;

    localparam int MC_MAX = 8;
    localparam int CNT_W  = 16;

    logic clk = 1'b0;
    logic reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic LoadE, LoadM, PCSrcE, MulDivStartE, MulDivDoneE;
    logic [1:0] ForwardAE, ForwardBE;
    logic StallF, StallD, StallE, FlushD, FlushE, FlushM, McTimeout;
    mc_state_t mc_state;
    logic [$clog2(MC_MAX+1)-1:0] mc_cnt;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] StallCycles, FlushCount, McCycles;
`endif

    int checks = 0;
    int errors = 0;

    hazard_unit_mc #(.LOAD_USE_DIST(2), .MC_MAX(MC_MAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .LoadE(LoadE), .LoadM(LoadM), .PCSrcE(PCSrcE),
        .MulDivStartE(MulDivStartE), .MulDivDoneE(MulDivDoneE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .McTimeout(McTimeout),
`ifdef HAZARD_PERF_CNT_EN
        .StallCycles(StallCycles), .FlushCount(FlushCount), .McCycles(McCycles),
`endif
        .mc_state(mc_state), .mc_cnt(mc_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] flags();
        return {StallF, StallD, StallE, FlushD, FlushE, FlushM};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        LoadE = 0; LoadM = 0; PCSrcE = 0; MulDivStartE = 0; MulDivDoneE = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        Rs1E = 5; RdM = 5; MulDivStartE = 1;
        #2;
        checks++;
        if (flags() !== 6'b000111) begin
            errors++; $display("FAIL reset_flags: got %b want %b", flags(), 6'b000111);
        end
        checks++;
        if (ForwardAE !== FWD_RF) begin
            errors++; $display("FAIL reset_fwd: got %b want %b", ForwardAE, FWD_RF);
        end
        checks++;
        if (McTimeout !== 1'b0 || mc_state !== MC_IDLE || mc_cnt !== '0) begin
            errors++; $display("FAIL reset_state: got to=%b st=%0d cnt=%0d want 0/0/0",
                               McTimeout, mc_state, mc_cnt);
        end
        step();
        MulDivStartE = 0;
        reset = 1'b0;
        #1;
        checks++;
        if (flags() !== 6'b000000 || ForwardAE !== FWD_MEM) begin
            errors++; $display("FAIL reset_release: got flags=%b fwdA=%b want 000000/10",
                               flags(), ForwardAE);
        end
        clear_inputs();
    endtask

    task automatic test_forwarding();
        Rs1E = 5; RdM = 5; RdW = 5; #1;
        checks++;
        if (ForwardAE !== 2'b10) begin
            errors++; $display("FAIL fwd_mem_priority: got %b want 10", ForwardAE);
        end
        RdM = 0; #1;
        checks++;
        if (ForwardAE !== 2'b01) begin
            errors++; $display("FAIL fwd_wb: got %b want 01", ForwardAE);
        end
        Rs1E = 0; RdM = 0; RdW = 0; #1;
        checks++;
        if (ForwardAE !== 2'b00) begin
            errors++; $display("FAIL fwd_rf: got %b want 00", ForwardAE);
        end
        Rs1E = 0; RdM = 0; RdW = 0; Rs2E = 0; #1;
        Rs2E = 3; RdW = 3; RdM = 9; #1;
        checks++;
        if (ForwardBE !== 2'b01 || ForwardAE !== 2'b00) begin
            errors++; $display("FAIL fwd_b_wb: got B=%b A=%b want 01/00", ForwardBE, ForwardAE);
        end
        RdM = 3; #1;
        checks++;
        if (ForwardBE !== 2'b10) begin
            errors++; $display("FAIL fwd_b_mem: got %b want 10", ForwardBE);
        end
        Rs1E = 0; RdM = 0; RdW = 0; #1;
        checks++;
        if (ForwardAE !== 2'b00) begin
            errors++; $display("FAIL fwd_x0: got %b want 00", ForwardAE);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_load_use();
        LoadE = 1; RdE = 7; Rs2D = 7; #1;
        checks++;
        if (flags() !== 6'b110010) begin
            errors++; $display("FAIL lu_e_stall: got %b want 110010", flags());
        end
        step();
        LoadE = 0; RdE = 0; LoadM = 1; RdM = 7; #1;
        checks++;
        if (flags() !== 6'b110010) begin
            errors++; $display("FAIL lu_m_stall: got %b want 110010", flags());
        end
        step();
        LoadM = 0; RdM = 0; #1;
        checks++;
        if (flags() !== 6'b000000) begin
            errors++; $display("FAIL lu_clear: got %b want 000000", flags());
        end
        LoadE = 1; RdE = 0; Rs1D = 0; Rs2D = 0; #1;
        checks++;
        if (flags() !== 6'b000000) begin
            errors++; $display("FAIL lu_x0: got %b want 000000", flags());
        end
        clear_inputs();
        step();
    endtask

    task automatic test_branch_priority();
        LoadE = 1; RdE = 7; Rs1D = 7; PCSrcE = 1; #1;
        checks++;
        if (flags() !== 6'b000110) begin
            errors++; $display("FAIL branch_over_lu: got %b want 000110", flags());
        end
        LoadE = 0; RdE = 0; #1;
        checks++;
        if (flags() !== 6'b000110) begin
            errors++; $display("FAIL branch_only: got %b want 000110", flags());
        end
        clear_inputs();
        step();
    endtask

    task automatic test_muldiv();
        MulDivDoneE = 1; #1;
        checks++;
        if (flags() !== 6'b000000) begin
            errors++; $display("FAIL done_in_idle: got %b want 000000", flags());
        end
        step();
        checks++;
        if (mc_state !== MC_IDLE) begin
            errors++; $display("FAIL done_in_idle_state: got %0d want 0", mc_state);
        end
        MulDivDoneE = 0;
        MulDivStartE = 1;
        for (int i = 0; i <= 4; i++) begin
            MulDivDoneE = (i == 4);
            #1;
            checks++;
            if (flags() !== (i < 4 ? 6'b111001 : 6'b000000) || mc_cnt !== i) begin
                errors++; $display("FAIL mc_cycle%0d: got flags=%b cnt=%0d want %b cnt=%0d",
                                   i, flags(), mc_cnt, (i < 4 ? 6'b111001 : 6'b000000), i);
            end
            step();
        end
        MulDivStartE = 0; MulDivDoneE = 0; #1;
        checks++;
        if (mc_state !== MC_IDLE || mc_cnt !== '0 || flags() !== 6'b000000) begin
            errors++; $display("FAIL mc_return_idle: got st=%0d cnt=%0d flags=%b want 0/0/000000",
                               mc_state, mc_cnt, flags());
        end
        clear_inputs();
        step();
    endtask

    task automatic test_back_to_back();
        MulDivStartE = 1;
        for (int i = 0; i < 6; i++) begin
            MulDivDoneE = (i == 2 || i == 5);
            #1;
            checks++;
            if (StallE !== !(i == 2 || i == 5) ||
                mc_state !== ((i == 0 || i == 3) ? MC_IDLE : MC_BUSY)) begin
                errors++; $display("FAIL b2b_cycle%0d: got stallE=%b st=%0d want %b st=%0d",
                                   i, StallE, mc_state, !(i == 2 || i == 5),
                                   ((i == 0 || i == 3) ? 0 : 1));
            end
            step();
        end
        clear_inputs();
        step();
    endtask

    task automatic test_timeout();
        MulDivStartE = 1;
        for (int i = 0; i <= MC_MAX; i++) begin
            #1;
            checks++;
            if (flags() !== (i < MC_MAX ? 6'b111001 : 6'b000000) || McTimeout !== 1'b0) begin
                errors++; $display("FAIL wd_cycle%0d: got flags=%b to=%b want %b to=0",
                                   i, flags(), McTimeout, (i < MC_MAX ? 6'b111001 : 6'b000000));
            end
            step();
        end
        MulDivStartE = 0;
        #1;
        checks++;
        if (McTimeout !== 1'b1 || mc_state !== MC_IDLE) begin
            errors++; $display("FAIL wd_pulse: got to=%b st=%0d want 1/0", McTimeout, mc_state);
        end
        step();
        checks++;
        if (McTimeout !== 1'b0) begin
            errors++; $display("FAIL wd_pulse_end: got %b want 0", McTimeout);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_reset_mid_busy();
        MulDivStartE = 1;
        step(); step(); step();
        checks++;
        if (mc_cnt !== 3 || mc_state !== MC_BUSY) begin
            errors++; $display("FAIL mid_busy_setup: got cnt=%0d st=%0d want 3/1", mc_cnt, mc_state);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (flags() !== 6'b000111 || McTimeout !== 1'b0 || mc_state !== MC_IDLE || mc_cnt !== '0) begin
            errors++; $display("FAIL mid_busy_reset: got flags=%b to=%b st=%0d cnt=%0d want 000111/0/0/0",
                               flags(), McTimeout, mc_state, mc_cnt);
        end
        step();
        MulDivStartE = 0;
        reset = 1'b0;
        step();
        checks++;
        if (mc_state !== MC_IDLE || mc_cnt !== '0 || flags() !== 6'b000000) begin
            errors++; $display("FAIL after_reset: got st=%0d cnt=%0d flags=%b want 0/0/000000",
                               mc_state, mc_cnt, flags());
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch_priority();
        test_muldiv();
        test_back_to_back();
        test_timeout();
        test_reset_mid_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
